// File: rtl/usb_tx_ctrl.sv
// usb_tx_ctrl: USB packet transmitter (sync, NRZI data, bit stuffing, EOP).
// Each line bit lasts 8 clk cycles; data bytes come from a FWFT FIFO.
module usb_tx_ctrl (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       fifo_empty,
  output logic       fifo_read,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    EOP1,
    EOP2,
    EOPJ
  } state_t;

  localparam logic [7:0] SYNC_B = 8'b1000_0000;

  state_t     state_q, state_d;
  logic [2:0] tmr_q, tmr_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] ones_q, ones_d;
  logic [7:0] sh_q, sh_d;
  logic       lvl_q, lvl_d;
  logic       se0_q, se0_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       bnd;
  logic       adv;
  logic       snd;
  logic       sbit;

  // Byte boundary: last period of bit 7, or of the stuff bit after it.
  assign bnd = (tmr_q == 3'd7) && (idx_q == 3'd7) &&
               ((state_q == STUFF) ||
                (((state_q == SYNC) || (state_q == DATA)) &&
                 (ones_q != 3'd6)));

  assign fifo_read = bnd & ~fifo_empty;
  assign d_plus    = lvl_q & ~se0_q;
  assign d_minus   = ~lvl_q & ~se0_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    ones_d  = ones_q;
    sh_d    = sh_q;
    lvl_d   = lvl_q;
    se0_d   = se0_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    adv     = 1'b0;
    snd     = 1'b0;
    sbit    = 1'b0;

    if (state_q == IDLE) begin
      if (tx_start) begin
        state_d = SYNC;
        tmr_d   = 3'd0;
        idx_d   = 3'd0;
        ones_d  = 3'd0;
        sh_d    = SYNC_B;
        lvl_d   = 1'b1;
        busy_d  = 1'b1;
        snd     = 1'b1;
        sbit    = SYNC_B[0];
      end
    end else begin
      tmr_d  = tmr_q + 3'd1;
      done_d = (state_q == EOPJ) && (tmr_q == 3'd6);
      if (tmr_q == 3'd7) begin
        unique case (state_q)
          SYNC, DATA: begin
            if (ones_q == 3'd6) begin
              state_d = STUFF;
              lvl_d   = ~lvl_q;
              ones_d  = 3'd0;
            end else begin
              adv = 1'b1;
            end
          end
          STUFF: adv = 1'b1;
          EOP1:  state_d = EOP2;
          EOP2: begin
            state_d = EOPJ;
            se0_d   = 1'b0;
            lvl_d   = 1'b1;
          end
          EOPJ: begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
          default: ;
        endcase
      end
    end

    if (adv) begin
      if (idx_q != 3'd7) begin
        state_d = (state_q == SYNC) ? SYNC : DATA;
        idx_d   = idx_q + 3'd1;
        snd     = 1'b1;
        sbit    = sh_q[idx_d];
      end else if (fifo_empty) begin
        state_d = EOP1;
        se0_d   = 1'b1;
      end else begin
        state_d = DATA;
        idx_d   = 3'd0;
        sh_d    = tx_data;
        snd     = 1'b1;
        sbit    = tx_data[0];
      end
    end

    // NRZI: a 0 toggles the line and breaks the run of ones.
    if (snd) begin
      if (!sbit) begin
        lvl_d  = ~lvl_d;
        ones_d = 3'd0;
      end else begin
        ones_d = ones_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      tmr_q   <= 3'd0;
      idx_q   <= 3'd0;
      ones_q  <= 3'd0;
      sh_q    <= 8'd0;
      lvl_q   <= 1'b1;
      se0_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      sh_q    <= sh_d;
      lvl_q   <= lvl_d;
      se0_q   <= se0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// tb_usb_tx_ctrl: directed and random packets checked cycle by cycle
// against a bitstream-level model of sync, stuffing, NRZI and EOP.
module tb_usb_tx_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data;
  logic       fifo_empty;
  logic       fifo_read;
  logic       d_plus;
  logic       d_minus;
  logic       tx_busy;
  logic       tx_done;

  int checks = 0;
  int failures = 0;

  logic [7:0] fifo[$];
  logic [7:0] pkt[$];
  logic [1:0] exp_ln[$];
  bit         rdmap[$];

  always #5 clk = ~clk;

  usb_tx_ctrl dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .fifo_empty(fifo_empty),
    .fifo_read (fifo_read),
    .d_plus    (d_plus),
    .d_minus   (d_minus),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fifo.size() == 0);
    tx_data    = (fifo.size() != 0) ? fifo[0] : 8'($urandom);
  endtask

  // Expected line state per bit period and FIFO pop cycles for pkt.
  task automatic build();
    logic       lvl;
    int         ones;
    logic [7:0] v;
    int         rd_cyc[$];
    exp_ln.delete();
    rdmap.delete();
    lvl  = 1'b1;
    ones = 0;
    for (int k = 0; k <= pkt.size(); k++) begin
      v = (k == 0) ? 8'h80 : pkt[k-1];
      for (int i = 0; i < 8; i++) begin
        if (v[i]) ones++;
        else begin
          ones = 0;
          lvl  = ~lvl;
        end
        exp_ln.push_back(lvl ? 2'b10 : 2'b01);
        if (ones == 6) begin
          ones = 0;
          lvl  = ~lvl;
          exp_ln.push_back(lvl ? 2'b10 : 2'b01);
        end
      end
      if (k < pkt.size()) rd_cyc.push_back(exp_ln.size() * 8 - 1);
    end
    exp_ln.push_back(2'b00);
    exp_ln.push_back(2'b00);
    exp_ln.push_back(2'b10);
    for (int c = 0; c < exp_ln.size() * 8; c++) rdmap.push_back(1'b0);
    foreach (rd_cyc[j]) rdmap[rd_cyc[j]] = 1'b1;
  endtask

  task automatic start_pkt();
    fifo = pkt;
    drive_fifo();
    build();
    @(negedge clk);
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  task automatic step(output logic pop);
    pop = fifo_read;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    if (pop && fifo.size() > 0) void'(fifo.pop_front());
    drive_fifo();
  endtask

  task automatic run_pkt(input string tag);
    int   n;
    logic pop;
    start_pkt();
    n = exp_ln.size() * 8;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk({tag, "_cyc"},
          {d_plus, d_minus, tx_busy, tx_done, fifo_read},
          {exp_ln[c/8], 1'b1, (c == n - 1), rdmap[c]});
      tx_start = ($urandom_range(0, 7) == 0);
      step(pop);
    end
    @(negedge clk);
    chk({tag, "_end"}, {d_plus, d_minus, tx_busy, tx_done, fifo_read},
        5'b10000);
    chk({tag, "_left"}, fifo.size(), 0);
  endtask

  task automatic idle_chk(input string tag, input int cyc);
    for (int c = 0; c < cyc; c++) begin
      @(negedge clk);
      chk(tag, {d_plus, d_minus, tx_busy, tx_done, fifo_read}, 5'b10000);
    end
  endtask

  initial begin
    logic pop;
    fifo.delete();
    drive_fifo();
    #12;
    chk("reset", {d_plus, d_minus, tx_busy, tx_done, fifo_read}, 5'b10000);
    @(negedge clk);
    n_rst = 1'b1;
    idle_chk("idle_after_rst", 6);

    pkt = '{8'h00};
    run_pkt("b00");
    idle_chk("gap0", 3);

    pkt = '{8'hFF};
    run_pkt("bFF");

    pkt = '{8'h3F};
    run_pkt("b3F");

    pkt.delete();
    run_pkt("empty");

    pkt = '{8'hA5, 8'h5A, 8'h01};
    run_pkt("a55a01");
    idle_chk("gap1", 2);

    for (int r = 0; r < 6; r++) begin
      pkt.delete();
      repeat ($urandom_range(0, 3))
        pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      run_pkt("rand");
    end

    pkt = '{8'hC3, 8'h7E};
    start_pkt();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("pre_rst", {d_plus, d_minus, tx_busy, tx_done, fifo_read},
          {exp_ln[c/8], 1'b1, 1'b0, rdmap[c]});
      step(pop);
    end
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    chk("rst_mid", {d_plus, d_minus, tx_busy, tx_done, fifo_read}, 5'b10000);
    @(negedge clk);
    chk("rst_hold", {d_plus, d_minus, tx_busy, tx_done, fifo_read},
        5'b10000);
    n_rst = 1'b1;
    fifo.delete();
    drive_fifo();
    idle_chk("idle_post", 4);

    pkt = '{8'hFF, 8'h80};
    run_pkt("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
